// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline control types: sequencer states, stage control bundle
// and the canonical control patterns used by the hazard/stall controller.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RESET    = 2'd0,
    RUN      = 2'd1,
    MD_BUSY  = 2'd2,
    MEM_WAIT = 2'd3
  } ctrl_state_e;

  // Longest legal mul/div EX occupancy; also sizes the occupancy counter.
  localparam int MD_LAT_MAX = 15;
  localparam int MD_CNT_W   = $clog2(MD_LAT_MAX + 1);

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_mem_bubble;
    logic mem_wb_bubble;
    logic md_done;
  } stage_ctrl_t;

  // Field order: pc, if_id, id_ex, ex_mem writes | flush, id_ex, ex_mem, mem_wb bubbles | md_done
  localparam stage_ctrl_t CTRL_RESET    = 9'b0000_1111_0;
  localparam stage_ctrl_t CTRL_RUN      = 9'b1111_0000_0;
  localparam stage_ctrl_t CTRL_MEM_HOLD = 9'b0000_0001_0;
  // EX keeps the mul/div; a bubble goes into EX/MEM each busy cycle.
  localparam stage_ctrl_t CTRL_MD_HOLD  = 9'b0001_0010_0;
  localparam stage_ctrl_t CTRL_MD_DONE  = 9'b1111_0000_1;
  localparam stage_ctrl_t CTRL_BRANCH   = 9'b1111_1100_0;
  localparam stage_ctrl_t CTRL_LOAD_USE = 9'b0011_0100_0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: clears on reset, counts inc pulses, sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // Count qualified cycles, holding once every bit is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller: load-use stalls, mul/div EX occupancy,
// data-memory wait states and branch flushes for the 5-stage core.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RESET    | reset asserted; everything frozen and bubbled
// RUN      | normal issue; branch flush / load-use stall applied here
// MD_BUSY  | mul/div occupying EX, md_cnt counts remaining busy cycles
// MEM_WAIT | data memory stalled; ret_state remembers where to resume
module hazard_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IF_ID_Register_Rs,
  input  logic [4:0]       IF_ID_Register_Rt,
  input  logic             IF_ID_Uses_Rt,
  input  logic [4:0]       ID_EX_Register_Rt,
  input  logic             ID_EX_MemRead,
  input  logic             ID_EX_MD_Start,
  input  logic             Branch_Taken,
  input  logic             Mem_Req,
  input  logic             Mem_Ready,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             ID_EX_Write,
  output logic             EX_MEM_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             EX_MEM_Bubble,
  output logic             MEM_WB_Bubble,
  output logic             MD_Done,
  output logic [CNT_W-1:0] Stall_Cycles
);

  // Start cycle plus the final done cycle bracket the counted busy cycles,
  // so the counter loads two less than the occupancy.
  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LATENCY - 2);

  ctrl_state_e          state_q, state_d;
  ctrl_state_e          ret_q, ret_d;
  logic [MD_CNT_W-1:0]  md_cnt_q, md_cnt_d;
  stage_ctrl_t          ctrl;
  logic                 mem_stall;
  logic                 load_use;
  logic                 md_pending;

  assign mem_stall  = Mem_Req && !Mem_Ready;
  assign md_pending = (md_cnt_q != '0);
  assign load_use   = ID_EX_MemRead && (ID_EX_Register_Rt != 5'd0) &&
                      ((ID_EX_Register_Rt == IF_ID_Register_Rs) ||
                       (IF_ID_Uses_Rt && (ID_EX_Register_Rt == IF_ID_Register_Rt)));

  // State, mul/div countdown and memory-wait return state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RESET;
      ret_q    <= RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // Next-state logic; memory wait outranks mul/div, and md_cnt freezes during it.
  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    md_cnt_d = md_cnt_q;
    case (state_q)
      RESET: begin
        state_d  = RUN;
        md_cnt_d = '0;
      end
      RUN: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
          ret_d   = RUN;
        end else if (ID_EX_MD_Start) begin
          state_d  = MD_BUSY;
          md_cnt_d = MD_LOAD;
        end
      end
      MD_BUSY: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
          ret_d   = MD_BUSY;
        end else if (md_pending) begin
          md_cnt_d = md_cnt_q - 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        // The release cycle doubles as a normal cycle of the resumed state,
        // so a wait inside MD_BUSY delays MD_Done by exactly the not-ready cycles.
        if (Mem_Ready) begin
          if (ret_q == MD_BUSY && md_pending) begin
            state_d  = MD_BUSY;
            md_cnt_d = md_cnt_q - 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Stage controls, combinational from state and hazard inputs.
  always_comb begin
    ctrl = CTRL_RUN;
    case (state_q)
      RESET: ctrl = CTRL_RESET;
      RUN: begin
        if (mem_stall)           ctrl = CTRL_MEM_HOLD;
        else if (ID_EX_MD_Start) ctrl = CTRL_MD_HOLD;
        else if (Branch_Taken)   ctrl = CTRL_BRANCH;
        else if (load_use)       ctrl = CTRL_LOAD_USE;
      end
      MD_BUSY: begin
        if (mem_stall)       ctrl = CTRL_MEM_HOLD;
        else if (md_pending) ctrl = CTRL_MD_HOLD;
        else                 ctrl = CTRL_MD_DONE;
      end
      MEM_WAIT: begin
        if (!Mem_Ready)           ctrl = CTRL_MEM_HOLD;
        else if (ret_q == MD_BUSY) ctrl = md_pending ? CTRL_MD_HOLD : CTRL_MD_DONE;
        else                      ctrl = CTRL_RUN;
      end
      default: ctrl = CTRL_RESET;
    endcase
  end

  assign PC_Write      = ctrl.pc_write;
  assign IF_ID_Write   = ctrl.if_id_write;
  assign ID_EX_Write   = ctrl.id_ex_write;
  assign EX_MEM_Write  = ctrl.ex_mem_write;
  assign IF_ID_Flush   = ctrl.if_id_flush;
  assign ID_EX_Bubble  = ctrl.id_ex_bubble;
  assign EX_MEM_Bubble = ctrl.ex_mem_bubble;
  assign MEM_WB_Bubble = ctrl.mem_wb_bubble;
  assign MD_Done       = ctrl.md_done;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   ((state_q != RESET) && !ctrl.pc_write),
    .count (Stall_Cycles)
  );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller (MD_LATENCY=4, CNT_W=4).
module tb_hazard_stall_controller;

  // {PC, IF_ID, ID_EX, EX_MEM writes | IF_ID_Flush, ID_EX, EX_MEM, MEM_WB bubbles | MD_Done}
  localparam logic [8:0] O_RST  = 9'b0000_1111_0;
  localparam logic [8:0] O_RUN  = 9'b1111_0000_0;
  localparam logic [8:0] O_LU   = 9'b0011_0100_0;
  localparam logic [8:0] O_BR   = 9'b1111_1100_0;
  localparam logic [8:0] O_MD   = 9'b0001_0010_0;
  localparam logic [8:0] O_DONE = 9'b1111_0000_1;
  localparam logic [8:0] O_MEM  = 9'b0000_0001_0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs, rt, ex_rt;
  logic       uses_rt, mem_read, md_start, br, mreq, mrdy;
  logic       pc_w, ifid_w, idex_w, exmem_w, flush, idex_b, exmem_b, memwb_b, md_done;
  logic [3:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_stall_controller #(
    .MD_LATENCY (4),
    .CNT_W      (4)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .IF_ID_Register_Rs (rs),
    .IF_ID_Register_Rt (rt),
    .IF_ID_Uses_Rt     (uses_rt),
    .ID_EX_Register_Rt (ex_rt),
    .ID_EX_MemRead     (mem_read),
    .ID_EX_MD_Start    (md_start),
    .Branch_Taken      (br),
    .Mem_Req           (mreq),
    .Mem_Ready         (mrdy),
    .PC_Write          (pc_w),
    .IF_ID_Write       (ifid_w),
    .ID_EX_Write       (idex_w),
    .EX_MEM_Write      (exmem_w),
    .IF_ID_Flush       (flush),
    .ID_EX_Bubble      (idex_b),
    .EX_MEM_Bubble     (exmem_b),
    .MEM_WB_Bubble     (memwb_b),
    .MD_Done           (md_done),
    .Stall_Cycles      (stall_cnt)
  );

  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic       uses_rt;
    logic [4:0] ex_rt;
    logic       mem_read, md_start, br, mreq, mrdy;
    logic [8:0] exp_o;
    logic [3:0] exp_c;
  } vec_t;

  typedef struct {
    string      name;
    logic [8:0] o;
    logic [3:0] c;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  vec_t t1[25];
  vec_t t2[7];
  vec_t t3[5];

  function automatic vec_t mk(input string n, input logic [4:0] a_rs, input logic [4:0] a_rt,
                              input logic a_urt, input logic [4:0] a_ert, input logic a_mr,
                              input logic a_md, input logic a_br, input logic a_mq,
                              input logic a_my, input logic [8:0] eo, input logic [3:0] ec);
    vec_t v;
    v.name = n; v.rs = a_rs; v.rt = a_rt; v.uses_rt = a_urt; v.ex_rt = a_ert;
    v.mem_read = a_mr; v.md_start = a_md; v.br = a_br; v.mreq = a_mq; v.mrdy = a_my;
    v.exp_o = eo; v.exp_c = ec;
    return v;
  endfunction

  function automatic logic [8:0] outs();
    return {pc_w, ifid_w, idex_w, exmem_w, flush, idex_b, exmem_b, memwb_b, md_done};
  endfunction

  task automatic check_o(input string nm, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: controls got %b expected %b", nm, got, exp);
  endtask

  task automatic check_c(input string nm, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: Stall_Cycles got %0d expected %0d", nm, got, exp);
  endtask

  task automatic drive_idle();
    rs = 5'd1; rt = 5'd2; uses_rt = 1'b1; ex_rt = 5'd3;
    mem_read = 1'b0; md_start = 1'b0; br = 1'b0; mreq = 1'b0; mrdy = 1'b1;
  endtask

  // One cycle: drive after the edge, queue the expectation, compare at negedge.
  task automatic apply(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    rs = v.rs; rt = v.rt; uses_rt = v.uses_rt; ex_rt = v.ex_rt;
    mem_read = v.mem_read; md_start = v.md_start; br = v.br; mreq = v.mreq; mrdy = v.mrdy;
    e.name = v.name; e.o = v.exp_o; e.c = v.exp_c;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check_o(e.name, outs(), e.o);
    check_c(e.name, stall_cnt, e.c);
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    #1;
    check_o({nm, "_assert"}, outs(), O_RST);
    check_c({nm, "_assert"}, stall_cnt, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_o({nm, "_hold"}, outs(), O_RST);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //                name             rs rt urt ert mr md br mq my  out     cnt
    t1[0]  = mk("idle",          1, 2, 1, 3, 0, 0, 0, 0, 1, O_RUN,  0);
    t1[1]  = mk("lu_rs",         5, 2, 1, 5, 1, 0, 0, 0, 1, O_LU,   0);
    t1[2]  = mk("after_lu",      5, 2, 1, 5, 0, 0, 0, 0, 1, O_RUN,  1);
    t1[3]  = mk("lu_rt",         1, 7, 1, 7, 1, 0, 0, 0, 1, O_LU,   1);
    t1[4]  = mk("rt_unused",     1, 7, 0, 7, 1, 0, 0, 0, 1, O_RUN,  2);
    t1[5]  = mk("rt_zero",       0, 0, 1, 0, 1, 0, 0, 0, 1, O_RUN,  2);
    t1[6]  = mk("br_over_lu",    5, 2, 1, 5, 1, 0, 1, 0, 1, O_BR,   2);
    t1[7]  = mk("idle2",         1, 2, 1, 3, 0, 0, 0, 0, 1, O_RUN,  2);
    t1[8]  = mk("md_start",      1, 2, 1, 3, 0, 1, 0, 0, 1, O_MD,   2);
    t1[9]  = mk("md_busy1",      1, 2, 1, 3, 0, 1, 0, 0, 1, O_MD,   3);
    t1[10] = mk("md_busy2",      1, 2, 1, 3, 0, 1, 0, 0, 1, O_MD,   4);
    t1[11] = mk("md_done",       1, 2, 1, 3, 0, 1, 0, 0, 1, O_DONE, 5);
    t1[12] = mk("md_after",      1, 2, 1, 3, 0, 0, 0, 0, 1, O_RUN,  5);
    t1[13] = mk("mw_run",        1, 2, 1, 3, 0, 0, 0, 1, 0, O_MEM,  5);
    t1[14] = mk("mw_hold",       1, 2, 1, 3, 0, 0, 0, 1, 0, O_MEM,  6);
    t1[15] = mk("mw_release",    1, 2, 1, 3, 0, 0, 0, 1, 1, O_RUN,  7);
    t1[16] = mk("mem_ready_now", 1, 2, 1, 3, 0, 0, 0, 1, 1, O_RUN,  7);
    t1[17] = mk("mw_over_md_br", 1, 2, 1, 3, 0, 1, 1, 1, 0, O_MEM,  7);
    t1[18] = mk("mw_release2",   1, 2, 1, 3, 0, 0, 0, 1, 1, O_RUN,  8);
    t1[19] = mk("idle3",         1, 2, 1, 3, 0, 0, 0, 0, 1, O_RUN,  8);
    t1[20] = mk("md_over_br",    1, 2, 1, 3, 0, 1, 1, 0, 1, O_MD,   8);
    t1[21] = mk("md2_busy1",     1, 2, 1, 3, 0, 1, 0, 0, 1, O_MD,   9);
    t1[22] = mk("md2_busy2",     1, 2, 1, 3, 0, 1, 0, 0, 1, O_MD,  10);
    t1[23] = mk("md2_done",      1, 2, 1, 3, 0, 1, 0, 0, 1, O_DONE,11);
    t1[24] = mk("md2_after",     1, 2, 1, 3, 0, 0, 0, 0, 1, O_RUN, 11);

    t2[0] = mk("mdm_start",      1, 2, 1, 3, 0, 1, 0, 0, 1, O_MD,   0);
    t2[1] = mk("mdm_wait",       1, 2, 1, 3, 0, 1, 0, 1, 0, O_MEM,  1);
    t2[2] = mk("mdm_hold",       1, 2, 1, 3, 0, 1, 0, 1, 0, O_MEM,  2);
    t2[3] = mk("mdm_release",    1, 2, 1, 3, 0, 1, 0, 1, 1, O_MD,   3);
    t2[4] = mk("mdm_busy",       1, 2, 1, 3, 0, 1, 0, 0, 1, O_MD,   4);
    t2[5] = mk("mdm_done",       1, 2, 1, 3, 0, 1, 0, 0, 1, O_DONE, 5);
    t2[6] = mk("mdm_after",      1, 2, 1, 3, 0, 0, 0, 0, 1, O_RUN,  5);

    t3[0] = mk("rr_idle",        1, 2, 1, 3, 0, 0, 0, 0, 1, O_RUN,  0);
    t3[1] = mk("rr_md_start",    1, 2, 1, 3, 0, 1, 0, 0, 1, O_MD,   0);
    t3[2] = mk("rr_md_busy1",    1, 2, 1, 3, 0, 1, 0, 0, 1, O_MD,   1);
    t3[3] = mk("rr_md_busy2",    1, 2, 1, 3, 0, 1, 0, 0, 1, O_MD,   2);
    t3[4] = mk("rr_md_done",     1, 2, 1, 3, 0, 1, 0, 0, 1, O_DONE, 3);

    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    check_o("reset_outputs", outs(), O_RST);
    check_c("reset_count", stall_cnt, 4'd0);
    rst_n = 1'b1;
    #1;
    check_o("reset_release_hold", outs(), O_RST);

    foreach (t1[i]) apply(t1[i]);

    do_reset("reset2");
    foreach (t2[i]) apply(t2[i]);

    // Saturation: continuous load-use stall for 20 cycles.
    do_reset("reset3");
    for (int i = 0; i < 20; i++) begin
      apply(mk("sat_lu", 5, 2, 1, 5, 1, 0, 0, 0, 1, O_LU, (i > 15) ? 4'd15 : 4'(i)));
    end
    apply(mk("sat_final", 1, 2, 1, 3, 0, 0, 0, 0, 1, O_RUN, 4'd15));

    // Reset asserted mid-MD_BUSY must take effect immediately.
    apply(mk("mr_md_start", 1, 2, 1, 3, 0, 1, 0, 0, 1, O_MD, 4'd15));
    apply(mk("mr_md_busy",  1, 2, 1, 3, 0, 1, 0, 0, 1, O_MD, 4'd15));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_o("mid_md_reset_outputs", outs(), O_RST);
    check_c("mid_md_reset_count", stall_cnt, 4'd0);
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    foreach (t3[i]) apply(t3[i]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Pipeline sequencing controller for the 5-stage MIPS core. It detects load-use hazards and sequences multi-cycle multiply/divide occupancy of EX and data-memory wait states. It also issues branch flushes. From these it drives the per-stage write-enable and bubble controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It complements the forwarding unit: it covers every hazard that forwarding cannot resolve.

## Interface
- `MD_LATENCY`, default 4: EX occupancy in cycles of a mul/div instruction. Legal range is 2..15.
- `CNT_W`, default 16: width of the stall-cycle counter.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `IF_ID_Register_Rs`, `IF_ID_Register_Rt`  in  5 each  source registers of the instruction in ID.
- `IF_ID_Uses_Rt`  in  1  the instruction in ID reads Rt.
- `ID_EX_Register_Rt`  in  5  destination register of the instruction in EX.
- `ID_EX_MemRead`  in  1  the instruction in EX is a load.
- `ID_EX_MD_Start`  in  1  the instruction in EX is a mul/div.
- `Branch_Taken`  in  1  a branch resolved taken in EX.
- `Mem_Req`  in  1  the MEM stage holds a load or store.
- `Mem_Ready`  in  1  data memory completes the access this cycle.
- `PC_Write`, `IF_ID_Write`, `ID_EX_Write`, `EX_MEM_Write`  out  1 each  stage register update enables.
- `IF_ID_Flush`, `ID_EX_Bubble`, `EX_MEM_Bubble`, `MEM_WB_Bubble`  out  1 each  load zero controls into that register.
- `MD_Done`  out  1  mul/div result valid this cycle.
- `Stall_Cycles`  out  CNT_W  saturating count of cycles with `PC_Write`=0.

## Operation
- States:
  - RESET: entered asynchronously while `rst_n`=0.
  - RUN.
  - MD_BUSY: uses a 4-bit down-counter `md_cnt`.
  - MEM_WAIT: uses a `ret_state` register.
- Defaults in RUN with no hazard: all four write enables are 1; all flush/bubble outputs are 0; `MD_Done`=0.
- RESET:
  - All write enables are 0.
  - `IF_ID_Flush`, `ID_EX_Bubble`, `EX_MEM_Bubble` and `MEM_WB_Bubble` are 1.
  - `MD_Done`=0 and `Stall_Cycles`=0.
  - The first clock edge after `rst_n` rises goes to RUN.
- Priority, highest first: memory wait, mul/div, branch, load-use.
- Memory wait applies in RUN or MD_BUSY when `Mem_Req`=1 and `Mem_Ready`=0.
  - All write enables are 0 and `MEM_WB_Bubble`=1.
  - Next state is MEM_WAIT; `ret_state` saves the current state.
  - `md_cnt` is frozen.
- MEM_WAIT:
  - Holds the same freeze outputs while `Mem_Ready`=0.
  - On the cycle where `Mem_Ready`=1: all write enables are 1 and `MEM_WB_Bubble`=0. Next state is `ret_state`.
  - If `ret_state`=MD_BUSY, the front stages stay frozen as in MD_BUSY rules.
- Mul/div start, in RUN with `ID_EX_MD_Start`=1:
  - `PC_Write`, `IF_ID_Write` and `ID_EX_Write` are 0; `EX_MEM_Bubble`=1.
  - `md_cnt` loads MD_LATENCY-2; next state is MD_BUSY.
- MD_BUSY:
  - While `md_cnt`≠0: same freeze as at start; `md_cnt` decrements.
  - At `md_cnt`=0: `MD_Done`=1 and all write enables are 1. Next state is RUN.
  - Total EX occupancy is exactly MD_LATENCY cycles.
- Branch, in RUN with `Branch_Taken`=1 and no higher-priority event:
  - `IF_ID_Flush`=1 and `ID_EX_Bubble`=1; `PC_Write`=1.
  - Any load-use stall is suppressed.
- Load-use hazard, in RUN: `ID_EX_MemRead`=1, `ID_EX_Register_Rt`≠0, and `ID_EX_Register_Rt` equals `IF_ID_Register_Rs`, or equals `IF_ID_Register_Rt` with `IF_ID_Uses_Rt`=1.
  - `PC_Write`=0, `IF_ID_Write`=0, `ID_EX_Bubble`=1.
  - The state stays RUN; the bubble removes the condition next cycle.
- `Stall_Cycles` increments on every non-RESET cycle with `PC_Write`=0 and saturates at all-ones.

## Timing
- All outputs are combinational from state and inputs; there is no added latency.
- State, `md_cnt`, `ret_state` and `Stall_Cycles` are registered.
- Load-use costs exactly 1 cycle; a branch costs 2 flushed slots.
- Mul/div costs MD_LATENCY-1 stall cycles plus any memory-wait cycles.
- `ID_EX_MD_Start` is ignored outside RUN, so the held mul/div instruction cannot retrigger.
- `rst_n` falling in any state immediately forces RESET outputs and clears `md_cnt`.

## Structure
- Shared package `pipeline_ctrl_pkg`: state enum (RESET, RUN, MD_BUSY, MEM_WAIT) and a `MD_LAT_MAX`=15 constant. The forwarding unit and the top level reuse this package.
- One natural sub-module, `sat_counter`: a parameterised-width saturating counter that implements `Stall_Cycles`.

## Test plan
- Reset release: `rst_n` 0→1 → RESET outputs hold until the next edge, then RUN defaults; `Stall_Cycles`=0.
- Load-use: lw to $5 in EX, `IF_ID_Register_Rs`=5 → one cycle with `PC_Write`=0 and `ID_EX_Bubble`=1, then normal. Repeat with Rt=0 → no stall.
- Mul/div, MD_LATENCY=4: `ID_EX_MD_Start` for one cycle → 3 freeze cycles with `EX_MEM_Bubble`=1, then `MD_Done`=1; `Stall_Cycles`=3.
- Memory wait inside MD_BUSY: `Mem_Ready`=0 for 2 cycles → `md_cnt` frozen, `MD_Done` delayed by 2; `Stall_Cycles`=5.
- Branch plus load-use in the same cycle → flush only; `PC_Write`=1 and no stall.
- Saturation: CNT_W=4 with 20 stall cycles → `Stall_Cycles`=15. Reset mid-MD_BUSY → RESET outputs immediately, then clean RUN.
